// File: rtl/hilo_muldiv_unit_if.sv
// hilo_muldiv_unit_if: operand/funct inputs and HI/LO results of the multiply unit
interface hilo_muldiv_unit_if;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [5:0]  Signal;
    logic [63:0] hilo;
    logic        busy;
    logic        done;
    modport master (output dataA, dataB, Signal, input hilo, busy, done);
    modport slave  (input dataA, dataB, Signal, output hilo, busy, done);
endinterface

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: HI/LO register pair with a 32-iteration shift-add multiplier
module hilo_muldiv_unit #(
    parameter logic [5:0] MULT_F  = 6'b011000,
    parameter logic [5:0] MULTU_F = 6'b011001,
    parameter logic [5:0] MTHI_F  = 6'b010001,
    parameter logic [5:0] MTLO_F  = 6'b010011
) (
    input logic clk,
    input logic rst,
    hilo_muldiv_unit_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t      state;
    logic [63:0] mcand, acc, hilo_q, p;
    logic [31:0] mplier, mag_a, mag_b;
    logic [4:0]  cnt;
    logic        neg, busy_q, done_q, is_mult, is_mul;
    always_comb begin
        mag_a   = bus.dataA[31] ? ~bus.dataA + 32'd1 : bus.dataA;
        mag_b   = bus.dataB[31] ? ~bus.dataB + 32'd1 : bus.dataB;
        is_mult = bus.Signal == MULT_F;
        is_mul  = is_mult || bus.Signal == MULTU_F;
        p       = mplier[0] ? acc + mcand : acc;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            hilo_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE) begin
                if (is_mul) begin
                    // signed multiply runs on magnitudes; the sign is reapplied at the end
                    mcand  <= {32'b0, is_mult ? mag_a : bus.dataA};
                    mplier <= is_mult ? mag_b : bus.dataB;
                    neg    <= is_mult && (bus.dataA[31] ^ bus.dataB[31]);
                    acc    <= '0;
                    cnt    <= '0;
                    busy_q <= 1'b1;
                    state  <= RUN;
                end else if (bus.Signal == MTHI_F) begin
                    hilo_q[63:32] <= bus.dataA;
                end else if (bus.Signal == MTLO_F) begin
                    hilo_q[31:0] <= bus.dataA;
                end
            end else begin
                acc    <= p;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 5'd1;
                if (cnt == 5'd31) begin
                    hilo_q <= neg ? ~p + 64'd1 : p;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            end
        end
    end
    assign bus.hilo = hilo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Sequential 32×32 multiplier that owns the HI/LO register pair and drives the 64-bit `hilo` bus read by the ALU for MFHI (funct 16) and MFLO (funct 18). It decodes the same 6-bit funct `Signal` the ALU receives. It runs MULT/MULTU as a 32-iteration shift-add sequence, executes MTHI/MTLO as single-cycle writes, and reports `busy` so the pipeline control can stall HI/LO reads until the product lands.

## Interface
Parameters:
- `MULT_F`, 6'b011000, signed multiply funct (24)
- `MULTU_F`, 6'b011001, unsigned multiply funct (25)
- `MTHI_F`, 6'b010001, move-to-HI funct (17)
- `MTLO_F`, 6'b010011, move-to-LO funct (19)

Ports:
- `clk` in 1: single clock, all state updates on the rising edge
- `rst` in 1: synchronous, active-high reset
- `dataA` in 32: rs operand (multiplicand; MTHI/MTLO source)
- `dataB` in 32: rt operand (multiplier)
- `Signal` in 6: funct code, sampled every rising edge
- `hilo` out 64: {HI, LO} register, [63:32]=HI, [31:0]=LO
- `busy` out 1: high while a multiply is in progress
- `done` out 1: one-cycle pulse after the product is written to `hilo`

## Operation
- States: IDLE, RUN.
- IDLE, `Signal`==MULTU_F: latch `mcand`={32'b0,dataA} (64b), `mplier`=dataB, `acc`=0, `cnt`=0, `neg`=0, go to RUN.
- IDLE, `Signal`==MULT_F: same, but operands are latched as magnitudes (two's-complement negate if bit31 set), and `neg`=dataA[31]^dataB[31]. A magnitude of 0x80000000 is kept as unsigned 0x80000000.
- IDLE, MTHI_F: `hilo[63:32]`<=dataA. MTLO_F: `hilo[31:0]`<=dataA. Both take one edge, with no busy and no done.
- IDLE, any other funct: no state change.
- RUN, each edge: if `mplier[0]`, `acc`<=`acc`+`mcand` (64-bit, carry out discarded). Then `mcand`<<=1, `mplier`>>=1, `cnt`++.
- RUN, edge where `cnt`==31: the final iteration result `p` goes to `hilo`<= neg ? (~p+1) : p. Set `done`<=1 and return to IDLE.
- `busy`=1 exactly while in RUN (registered).
- In RUN, all `Signal` values are ignored, including MULT/MULTU/MTHI/MTLO. There is no queueing. The control stalls on `busy`.
- `hilo` holds its previous value for the whole multiply. It is updated only at completion, so stale reads are well defined.

## Timing
- Reset: state=IDLE, `hilo`=64'h0, `busy`=0, `done`=0, `cnt`=0, internal regs 0.
- `rst` mid-RUN: abort the multiply and apply the reset values at that edge. No partial product reaches `hilo`.
- Multiply issued at edge E0: `busy`=1 from after E0 through E32. `hilo` is updated at E32. `done`=1 for the single cycle after E32. `busy`=0 after E32.
- A new MULT/MULTU presented in the cycle after E32 is accepted at E33 (back-to-back, one idle edge minimum).
- MTHI/MTLO at edge E: the new `hilo` value is visible in the cycle after E.
- `done` is held low except for its one-cycle pulse. `done` and `busy` are never high in the same cycle.
- Output `hilo` is a register with no combinational path from inputs. The ALU's two-stage output delay is added by the consumer.

## Test plan
- Reset, then MULTU `dataA`=3, `dataB`=5 at E0 → `busy` for 32 cycles; at E32 `hilo`=64'h0000000000000000F, `done` one pulse.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hilo`=64'hFFFFFFFE_00000001 after E32.
- MULT 0xFFFFFFFE (−2) × 3 → `hilo`=64'hFFFFFFFF_FFFFFFFA. MULT 0x80000000 × 0x80000000 → 64'h40000000_00000000.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive edges → `hilo`=64'h12345678_9ABCDEF0 one cycle after the second, with `busy`/`done` never asserted. Then MULTU 7×6: MTHI 0xDEAD issued at E5 is ignored, and `hilo`=42 at E32.
- MULTU 0x10000×0x10000 started, `rst` at E10 → `busy`=0, `hilo`=0 after E10, no `done`. A new MULTU 2×2 then completes normally with `hilo`=4.
- Back-to-back: MULTU 1×1 completes at E32, MULTU 9×9 issued at E33 → `hilo`=1 after E32 and `hilo`=81 after E65.
